nuc_seq_sched: RTL and testbench



---
 rtl/nuc_seq_sched_pkg.sv | 30 +++
 rtl/nuc_seq_sched_if.sv | 44 ++++
 rtl/nuc_seq_sched_pack16.sv | 74 +++++++
 rtl/nuc_seq_sched.sv | 188 ++++++++++++++++++
 tb/tb_nuc_seq_sched.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nuc_seq_sched_pkg.sv
// rtl/nuc_seq_sched_pkg.sv - shared constants, state enum and helpers for nuc_seq_sched
package nuc_seq_sched_pkg;

  localparam int PROB_W     = 10;
  localparam int PROB_VEC_W = 4 * PROB_W;
  localparam int SUM_W      = 12;

  // Largest probability total the generator can normalise against.
  localparam logic [SUM_W-1:0] SUM_LIMIT = 12'd4093;

  localparam logic [1:0] NUC_A = 2'b00;
  localparam logic [1:0] NUC_C = 2'b01;
  localparam logic [1:0] NUC_G = 2'b10;
  localparam logic [1:0] NUC_T = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SEED,
    ST_PRIME,
    ST_RUN,
    ST_FLUSH
  } state_e;

  // Sum of the four probability fields {T,G,C,A}, A in the LSBs.
  function automatic logic [SUM_W-1:0] prob_sum(input logic [PROB_VEC_W-1:0] p);
    return SUM_W'(p[9:0]) + SUM_W'(p[19:10]) + SUM_W'(p[29:20]) + SUM_W'(p[39:30]);
  endfunction

endpackage

// File: rtl/nuc_seq_sched_if.sv
// rtl/nuc_seq_sched_if.sv - request, generator and output-stream bundle for nuc_seq_sched
interface nuc_seq_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 16
);
  import nuc_seq_sched_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*LEN_W-1:0]      req_len;
  logic [NUM_REQ*PROB_VEC_W-1:0] req_prob;

  logic [PROB_W-1:0] gen_prob_A;
  logic [PROB_W-1:0] gen_prob_C;
  logic [PROB_W-1:0] gen_prob_G;
  logic [PROB_W-1:0] gen_prob_T;
  logic [3:0]        gen_instance_id;
  logic              gen_reset;
  logic [1:0]        gen_result;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_nvalid;
  logic        out_last;
  logic [3:0]  out_src;

  // Requesters, generator and output sink seen from outside the scheduler.
  modport master (
    output req_valid, req_len, req_prob, gen_result, out_ready,
    input  req_ready, gen_prob_A, gen_prob_C, gen_prob_G, gen_prob_T,
           gen_instance_id, gen_reset, out_valid, out_data, out_nvalid,
           out_last, out_src
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_len, req_prob, gen_result, out_ready,
    output req_ready, gen_prob_A, gen_prob_C, gen_prob_G, gen_prob_T,
           gen_instance_id, gen_reset, out_valid, out_data, out_nvalid,
           out_last, out_src
  );

endinterface

// File: rtl/nuc_seq_sched_pack16.sv
// rtl/nuc_seq_sched_pack16.sv - nuc_pack16: packs 2-bit nucleotides 16 per 32-bit word with valid/ready
module nuc_pack16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_nvalid,
  output logic        out_last
);

  logic [31:0] data_q, data_d;
  logic [3:0]  pos_q, pos_d;
  logic        pend_q, pend_d;
  logic [4:0]  nvalid_q, nvalid_d;
  logic        last_q, last_d;
  logic        accept;

  assign accept     = pend_q && out_ready;
  // A pending word blocks capture unless it leaves this very cycle.
  assign in_ready   = !pend_q || out_ready;
  assign out_valid  = pend_q;
  assign out_data   = data_q;
  assign out_nvalid = nvalid_q;
  assign out_last   = last_q;

  // Next word contents: release on accept, then drop a new sample into slot pos.
  always_comb begin
    data_d   = data_q;
    pos_d    = pos_q;
    pend_d   = pend_q;
    nvalid_d = nvalid_q;
    last_d   = last_q;
    if (accept) begin
      pend_d   = 1'b0;
      data_d   = '0;
      nvalid_d = '0;
      last_d   = 1'b0;
    end
    if (in_valid && in_ready) begin
      data_d = data_d | (32'(in_data) << {pos_q, 1'b0});
      if (pos_q == 4'd15 || in_last) begin
        pend_d   = 1'b1;
        nvalid_d = 5'(pos_q) + 5'd1;
        last_d   = in_last;
        pos_d    = 4'd0;
      end else begin
        pos_d = pos_q + 4'd1;
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      pos_q    <= '0;
      pend_q   <= 1'b0;
      nvalid_q <= '0;
      last_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      pos_q    <= pos_d;
      pend_q   <= pend_d;
      nvalid_q <= nvalid_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/nuc_seq_sched.sv
// rtl/nuc_seq_sched.sv - round-robin job scheduler for a shared nucleotide generator; NUC_SEQ_STATS_EN adds per-job base counters
module nuc_seq_sched
  import nuc_seq_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 16,
  parameter int GEN_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  nuc_seq_sched_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           err
`ifdef NUC_SEQ_STATS_EN
  ,
  output logic [15:0]    stat_a,
  output logic [15:0]    stat_c,
  output logic [15:0]    stat_g,
  output logic [15:0]    stat_t
`endif
);

  state_e                  state_q, state_d;
  logic [3:0]              rr_ptr_q;
  logic [3:0]              src_q;
  logic [LEN_W-1:0]        len_q, rem_q;
  logic [PROB_VEC_W-1:0]   prob_q;
  logic [7:0]              prime_q;
  logic                    done_q, done_d;

  logic [15:0]             valid_ext;
  logic [4:0]              scan_idx;
  logic                    grant_found;
  logic [3:0]              grant_idx;
  logic                    grant;
  logic [LEN_W-1:0]        sel_len;
  logic [PROB_VEC_W-1:0]   sel_prob;
  logic [SUM_W-1:0]        sum;
  logic                    job_bad;
  logic                    pk_in_ready;
  logic                    capture;
  logic                    in_last;

  assign valid_ext = 16'(bus.req_valid);

  // Round-robin scan: first asserted request at or after rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 4'd0;
    scan_idx    = 5'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = 5'(rr_ptr_q) + 5'(k);
      if (scan_idx >= 5'(NUM_REQ)) scan_idx = scan_idx - 5'(NUM_REQ);
      if (!grant_found && valid_ext[scan_idx[3:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[3:0];
      end
    end
  end

  // Select the winner's length and probability fields.
  always_comb begin
    sel_len  = '0;
    sel_prob = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == 4'(k)) begin
        sel_len  = bus.req_len[k*LEN_W +: LEN_W];
        sel_prob = bus.req_prob[k*PROB_VEC_W +: PROB_VEC_W];
      end
    end
  end

  // No grant during the done cycle, so the next job starts after it.
  assign grant         = (state_q == ST_IDLE) && !done_q && grant_found && !reset;
  assign bus.req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

  assign sum     = prob_sum(prob_q);
  assign job_bad = (sum == '0) || (sum > SUM_LIMIT) || (len_q == '0);
  assign capture = (state_q == ST_RUN) && pk_in_ready;
  assign in_last = (rem_q == LEN_W'(1));

  // Job FSM next state plus err/done strobes.
  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (grant) state_d = ST_CHECK;
      ST_CHECK: begin
        if (job_bad) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEED;
        end
      end
      ST_SEED:  state_d = ST_PRIME;
      ST_PRIME: if (prime_q == 8'(GEN_LAT - 1)) state_d = ST_RUN;
      ST_RUN:   if (capture && in_last) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (bus.out_valid && bus.out_ready && bus.out_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, job latches, round-robin pointer and sample countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      prob_q   <= '0;
      prime_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (grant) begin
        len_q    <= sel_len;
        prob_q   <= sel_prob;
        src_q    <= grant_idx;
        rr_ptr_q <= (grant_idx == 4'(NUM_REQ - 1)) ? 4'd0 : grant_idx + 4'd1;
      end
      if (state_q == ST_CHECK) rem_q <= len_q;
      else if (capture)        rem_q <= rem_q - LEN_W'(1);
      if (state_q == ST_SEED)       prime_q <= '0;
      else if (state_q == ST_PRIME) prime_q <= prime_q + 8'd1;
    end
  end

  assign bus.gen_prob_A      = prob_q[9:0];
  assign bus.gen_prob_C      = prob_q[19:10];
  assign bus.gen_prob_G      = prob_q[29:20];
  assign bus.gen_prob_T      = prob_q[39:30];
  assign bus.gen_instance_id = src_q;
  assign bus.gen_reset       = (state_q == ST_SEED);
  assign bus.out_src         = src_q;
  assign busy                = (state_q != ST_IDLE);
  assign done                = done_q;

  nuc_pack16 u_pack (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (capture),
    .in_data    (bus.gen_result),
    .in_last    (in_last),
    .in_ready   (pk_in_ready),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready),
    .out_data   (bus.out_data),
    .out_nvalid (bus.out_nvalid),
    .out_last   (bus.out_last)
  );

`ifdef NUC_SEQ_STATS_EN
  logic [15:0] stat_a_q, stat_c_q, stat_g_q, stat_t_q;

  // Per-job base counts of captured samples; cleared when the generator is reseeded.
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_SEED) begin
      stat_a_q <= '0;
      stat_c_q <= '0;
      stat_g_q <= '0;
      stat_t_q <= '0;
    end else if (capture) begin
      case (bus.gen_result)
        NUC_A:   stat_a_q <= stat_a_q + 16'd1;
        NUC_C:   stat_c_q <= stat_c_q + 16'd1;
        NUC_G:   stat_g_q <= stat_g_q + 16'd1;
        default: stat_t_q <= stat_t_q + 16'd1;
      endcase
    end
  end

  assign stat_a = stat_a_q;
  assign stat_c = stat_c_q;
  assign stat_g = stat_g_q;
  assign stat_t = stat_t_q;
`endif

endmodule

// File: tb/tb_nuc_seq_sched.sv
// tb/tb_nuc_seq_sched.sv - scoreboard bench for nuc_seq_sched with a behavioural generator model
module tb_nuc_seq_sched;

  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 16;
  localparam int GEN_LAT = 2;
  localparam int DONE_LAT = 4 + GEN_LAT + 16;

  typedef struct {
    logic [31:0] data;
    int          nvalid;
    bit          last;
    int          src;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  logic busy, done, err;
`ifdef NUC_SEQ_STATS_EN
  logic [15:0] stat_a, stat_c, stat_g, stat_t;
`endif

  always #5 clk = ~clk;

  nuc_seq_sched_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();

  nuc_seq_sched #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .GEN_LAT(GEN_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
`ifdef NUC_SEQ_STATS_EN
    ,
    .stat_a (stat_a),
    .stat_c (stat_c),
    .stat_g (stat_g),
    .stat_t (stat_t)
`endif
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    gen_k    = 0;
  int    pend[NUM_REQ];
  word_t sb[$];
  int    grants[$];
  int    grant_cyc = 0;
  int    done_cyc  = 0;
  int    done_seen = 0;
  int    err_seen  = 0;
  int    done_exp  = 0;
  int    err_exp   = 0;
  int    words_seen = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Behavioural generator output sequence for instance id.
  function automatic logic [1:0] pat(input int n, input logic [3:0] id);
    int v;
    v = n * 5 + (n >>> 2) + int'(id) * 3;
    return v[1:0];
  endfunction

  function automatic int pend_total();
    int s = 0;
    foreach (pend[i]) s += pend[i];
    return s;
  endfunction

  // Expected words for a job whose samples are captured back to back.
  task automatic push_job(input int src, input int len);
    word_t w;
    int    n;
    for (int base = 0; base < len; base += 16) begin
      n = (len - base > 16) ? 16 : len - base;
      w.data = '0;
      for (int s = 0; s < n; s++) w.data = w.data | (32'(pat(base + s, 4'(src))) << (2 * s));
      w.nvalid = n;
      w.last   = (base + n == len);
      w.src    = src;
      sb.push_back(w);
    end
    done_exp++;
  endtask

  task automatic set_req(input int i, input int len, input logic [39:0] prob);
    bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
    bus.req_prob[i*40 +: 40]      = prob;
  endtask

  task automatic wait_quiet(input string nm, input int budget);
    int t = 0;
    @(negedge clk);
    while (t < budget && !(sb.size() == 0 && pend_total() == 0 && !busy && !done)) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_timeout"}, 64'(t < budget), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_gen_prob"}, 64'({bus.gen_prob_T, bus.gen_prob_G, bus.gen_prob_C, bus.gen_prob_A}), 64'd0);
    check({tag, "_gen_id"}, 64'(bus.gen_instance_id), 64'd0);
    check({tag, "_gen_reset"}, 64'(bus.gen_reset), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    check({tag, "_out_nvalid"}, 64'(bus.out_nvalid), 64'd0);
    check({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    check({tag, "_out_src"}, 64'(bus.out_src), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: restarts on gen_reset, first valid sample GEN_LAT cycles later.
  always @(posedge clk) begin
    if (bus.gen_reset) gen_k <= 0;
    else               gen_k <= gen_k + 1;
  end
  assign bus.gen_result = pat(gen_k - GEN_LAT, bus.gen_instance_id);

  // Requesters: hold valid while jobs remain, retire one per grant.
  initial begin
    logic [NUM_REQ-1:0] g;
    forever begin
      @(negedge clk);
      g = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g[i] && pend[i] > 0) pend[i]--;
        bus.req_valid[i] = (pend[i] > 0);
      end
    end
  end

  // Monitor: grants, strobes and output words against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (|bus.req_ready) begin
        check("grant_onehot", 64'($countones(bus.req_ready)), 64'd1);
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) grants.push_back(i);
        grant_cyc = cyc;
      end
      if (err) err_seen++;
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (bus.out_valid) begin
        check("word_gen_id", 64'(bus.gen_instance_id), 64'(bus.out_src));
        if (bus.out_ready) begin
          words_seen++;
          if (sb.size() == 0) begin
            check("unexpected_word", 64'(bus.out_data), 64'hdead_0000_0000);
          end else begin
            word_t w;
            w = sb.pop_front();
            check("word_data", 64'(bus.out_data), 64'(w.data));
            check("word_nvalid", 64'(bus.out_nvalid), 64'(w.nvalid));
            check("word_last", 64'(bus.out_last), 64'(w.last));
            check("word_src", 64'(bus.out_src), 64'(w.src));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [42:0] snap;
    int          t;
    int          ws;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.req_prob  = '0;
    bus.out_ready = 1'b1;
    foreach (pend[i]) pend[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    @(negedge clk);
    reset = 1'b0;

    // Single full word from requester 0.
    set_req(0, 16, {10'd256, 10'd256, 10'd256, 10'd256});
    push_job(0, 16);
    pend[0] = 1;
    wait_quiet("single", 200);
    check("single_done_latency", 64'(done_cyc - grant_cyc), 64'(DONE_LAT));
    check("single_grant_src", 64'(grants[$]), 64'd0);

    // Partial final word: 20 nucleotides, second word carries 4.
    set_req(3, 20, {10'd100, 10'd200, 10'd300, 10'd400});
    push_job(3, 20);
    pend[3] = 1;
    wait_quiet("partial", 200);

    // Round robin with everyone requesting: expect 0,1,2,3,0.
    grants.delete();
    set_req(0, 16, {10'd10, 10'd20, 10'd30, 10'd40});
    set_req(1, 5,  {10'd1, 10'd1, 10'd1, 10'd1});
    set_req(2, 17, {10'd500, 10'd0, 10'd0, 10'd9});
    set_req(3, 9,  {10'd7, 10'd7, 10'd7, 10'd7});
    push_job(0, 16);
    push_job(1, 5);
    push_job(2, 17);
    push_job(3, 9);
    push_job(0, 16);
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    wait_quiet("rr", 800);
    check("rr_grant_count", 64'(grants.size()), 64'd5);
    if (grants.size() == 5) begin
      check("rr_order0", 64'(grants[0]), 64'd0);
      check("rr_order1", 64'(grants[1]), 64'd1);
      check("rr_order2", 64'(grants[2]), 64'd2);
      check("rr_order3", 64'(grants[3]), 64'd3);
      check("rr_order4", 64'(grants[4]), 64'd0);
    end

    // Rejects: sum 4092 accepted, zero length and zero probabilities refused.
    set_req(1, 16, {10'd1023, 10'd1023, 10'd1023, 10'd1023});
    push_job(1, 16);
    pend[1] = 1;
    wait_quiet("max_prob", 200);
    set_req(2, 0, {10'd256, 10'd256, 10'd256, 10'd256});
    err_exp++;
    pend[2] = 1;
    wait_quiet("len_zero", 100);
    set_req(3, 8, 40'd0);
    err_exp++;
    pend[3] = 1;
    wait_quiet("prob_zero", 100);
    check("err_count", 64'(err_seen), 64'(err_exp));
    check("done_count", 64'(done_seen), 64'(done_exp));

    // Backpressure: pending word must hold for 50 cycles.
    bus.out_ready = 1'b0;
    set_req(0, 16, {10'd50, 10'd60, 10'd70, 10'd80});
    push_job(0, 16);
    pend[0] = 1;
    t = 0;
    while (t < 200 && !bus.out_valid) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", 64'(bus.out_valid), 64'd1);
    snap = {bus.out_valid, bus.out_data, bus.out_nvalid, bus.out_last, bus.out_src};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_hold", 64'({bus.out_valid, bus.out_data, bus.out_nvalid, bus.out_last, bus.out_src}), 64'(snap));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_quiet("bp", 100);
`ifdef NUC_SEQ_STATS_EN
    check("stats_sum", 64'(stat_a + stat_c + stat_g + stat_t), 64'd16);
`endif

    // Mid-job reset during RUN: outputs clear, job abandoned, pointer back to 0.
    set_req(1, 40, {10'd256, 10'd256, 10'd256, 10'd256});
    push_job(1, 40);
    done_exp--;
    t = grants.size();
    pend[1] = 1;
    ws = 0;
    while (ws < 100 && grants.size() == t) begin
      @(negedge clk);
      ws++;
    end
    check("mid_grant_seen", 64'(grants.size()), 64'(t + 1));
    while (cyc < grant_cyc + 10) @(negedge clk);
    reset = 1'b1;
    foreach (pend[i]) pend[i] = 0;
    sb.delete();
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    ws = words_seen;
    repeat (40) @(negedge clk);
    check("midrst_no_resume_busy", 64'(busy), 64'd0);
    check("midrst_no_words", 64'(words_seen), 64'(ws));
    check("midrst_no_done", 64'(done_seen), 64'(done_exp));

    grants.delete();
    set_req(0, 4, {10'd256, 10'd256, 10'd256, 10'd256});
    set_req(2, 4, {10'd256, 10'd256, 10'd256, 10'd256});
    push_job(0, 4);
    push_job(2, 4);
    pend[0] = 1; pend[2] = 1;
    wait_quiet("post_rst", 200);
    check("post_rst_first_grant", 64'(grants.size() > 0 ? grants[0] : 99), 64'd0);
    check("final_done_count", 64'(done_seen), 64'(done_exp));
    check("final_err_count", 64'(err_seen), 64'(err_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
